// File: rtl/rst_sequencer.sv
// Reset sequencer: debounced button + lock qualification, stretched then staggered per-domain release.
// Latency: lock loss to reset SYNC_STAGES+1 edges, button SYNC_STAGES+2^DEBOUNCE_BITS+1; no backpressure.
module rst_sequencer #(
    parameter int DEBOUNCE_BITS  = 16,
    parameter int NUM_LOCKS      = 2,
    parameter int NUM_DOMAINS    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   rstRaw,
    input  logic [NUM_LOCKS-1:0]   locked,
    input  logic                   clrStatus,
    output logic [NUM_DOMAINS-1:0] domainRst,
    output logic                   allReleased,
    output logic                   lockLost,
    output logic [1:0]             state
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0]                btn_sync_q, btn_sync_d;
    logic [DEBOUNCE_BITS-1:0]              btn_cnt_q, btn_cnt_d;
    logic                                  btn_state_q, btn_state_d;
    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [NUM_DOMAINS-1:0]                dom_rst_q, dom_rst_d;
    logic                                  all_rel_q, all_rel_d;
    logic                                  lock_lost_q, lock_lost_d;

    logic all_locked;
    logic btn_sync;
    logic abort;
    logic lock_set;

    always_comb begin
        lock_sync_d    = lock_sync_q;
        lock_sync_d[0] = locked;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            lock_sync_d[i] = lock_sync_q[i-1];
        end
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], rstRaw};
    end

    assign all_locked = &lock_sync_q[SYNC_STAGES-1];
    assign btn_sync   = btn_sync_q[SYNC_STAGES-1];

    // Symmetric debounce: the level only flips after a full counter wrap of unbroken mismatches.
    always_comb begin
        btn_cnt_d   = '0;
        btn_state_d = btn_state_q;
        if (btn_sync != btn_state_q) begin
            if (&btn_cnt_q) begin
                btn_state_d = btn_sync;
            end else begin
                btn_cnt_d = btn_cnt_q + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign abort = !all_locked || btn_state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        all_rel_d = all_rel_q;
        lock_set  = 1'b0;

        case (state_q)
            ST_HOLD: begin
                dom_rst_d = '1;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
                if (!abort) begin
                    state_d = ST_STRETCH;
                end
            end

            ST_STRETCH: begin
                if (abort) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    dom_rst_d[0] = 1'b0;
                    cnt_d        = '0;
                    idx_d        = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (abort) begin
                    state_d   = ST_HOLD;
                    dom_rst_d = '1;
                    all_rel_d = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    lock_set  = !all_locked;
                end else if (cnt_q == STAGGER_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            dom_rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_HOLD;
                    dom_rst_d = '1;
                    all_rel_d = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    lock_set  = !all_locked;
                end
            end

            default: begin
                state_d   = ST_HOLD;
                dom_rst_d = '1;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
            end
        endcase
    end

    // A set wins over a simultaneous clear so a lock loss is never silently dropped.
    assign lock_lost_d = lock_set || (lock_lost_q && !clrStatus);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '0;
            btn_cnt_q   <= '0;
            btn_state_q <= 1'b0;
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_q   <= '1;
            all_rel_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            btn_sync_q  <= btn_sync_d;
            btn_cnt_q   <= btn_cnt_d;
            btn_state_q <= btn_state_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_q   <= dom_rst_d;
            all_rel_q   <= all_rel_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign domainRst   = dom_rst_q;
    assign allReleased = all_rel_q;
    assign lockLost    = lock_lost_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random stimulus against a timeline-based reference model.
module tb_rst_sequencer;

    localparam int DB = 4;
    localparam int NL = 2;
    localparam int ND = 3;
    localparam int SC = 16;
    localparam int ST = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          rstRaw;
    logic [NL-1:0] locked;
    logic          clrStatus;
    logic [ND-1:0] domainRst;
    logic          allReleased;
    logic          lockLost;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    rst_sequencer #(
        .DEBOUNCE_BITS (DB),
        .NUM_LOCKS     (NL),
        .NUM_DOMAINS   (ND),
        .STRETCH_CYCLES(SC),
        .STAGGER_CYCLES(ST),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .rstRaw     (rstRaw),
        .locked     (locked),
        .clrStatus  (clrStatus),
        .domainRst  (domainRst),
        .allReleased(allReleased),
        .lockLost   (lockLost),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference model: input delay lines, a mismatch run length, and time elapsed since the stretch began.
    logic [NL-1:0] m_lock_pipe [SS];
    logic          m_btn_pipe  [SS];
    int            m_run;
    bit            m_btn;
    bit            m_active;
    int            m_elapsed;
    bit            m_lost;

    task automatic model_step();
        bit all_locked;
        bit bsync;
        bit abort;
        bit set_lost;
        if (!rstN) begin
            for (int i = 0; i < SS; i++) begin
                m_lock_pipe[i] = '0;
                m_btn_pipe[i]  = 1'b0;
            end
            m_run = 0; m_btn = 0; m_active = 0; m_elapsed = 0; m_lost = 0;
        end else begin
            all_locked = &m_lock_pipe[SS-1];
            bsync      = m_btn_pipe[SS-1];
            abort      = !all_locked || m_btn;
            set_lost   = 0;
            if (!m_active) begin
                if (!abort) begin
                    m_active  = 1;
                    m_elapsed = 0;
                end
            end else if (abort) begin
                if (m_elapsed >= SC && !all_locked) set_lost = 1;
                m_active = 0;
            end else if (m_elapsed < 1000000) begin
                m_elapsed++;
            end
            m_lost = set_lost || (m_lost && !clrStatus);
            if (bsync != m_btn) begin
                m_run++;
                if (m_run == (1 << DB)) begin
                    m_btn = bsync;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            for (int i = SS - 1; i > 0; i--) begin
                m_lock_pipe[i] = m_lock_pipe[i-1];
                m_btn_pipe[i]  = m_btn_pipe[i-1];
            end
            m_lock_pipe[0] = locked;
            m_btn_pipe[0]  = rstRaw;
        end
    endtask

    function automatic logic [ND-1:0] exp_rst();
        logic [ND-1:0] r;
        for (int k = 0; k < ND; k++) begin
            r[k] = !(m_active && m_elapsed >= SC + k * ST);
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_active)                     return 2'd0;
        if (m_elapsed < SC)                return 2'd1;
        if (m_elapsed < SC + (ND - 1) * ST) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check_val("m_domain_rst", domainRst, exp_rst());
        check_val("m_state", state, exp_state());
        check_val("m_all_released", allReleased, exp_state() == 2'd3);
        check_val("m_lock_lost", lockLost, m_lost);
    endtask

    // One clock: model advances on the edge, outputs are compared at the following falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        int entry;
        bit seen;

        rstN = 1'b0; rstRaw = 1'b0; locked = 2'b11; clrStatus = 1'b0;

        // 1. Power-up
        for (int i = 0; i < 4; i++) step();
        check_val("reset_domain_rst", domainRst, 3'b111);
        check_val("reset_state", state, 2'd0);
        rstN = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 2)  check_val("pu_e2_state", state, 2'd0);
            if (e == 3)  check_val("pu_e3_state", state, 2'd1);
            if (e == 18) check_val("pu_e18_rst", domainRst, 3'b111);
            if (e == 19) check_val("pu_e19_rst", domainRst, 3'b110);
            if (e == 27) check_val("pu_e27_rst", domainRst, 3'b100);
            if (e == 35) begin
                check_val("pu_e35_rst", domainRst, 3'b000);
                check_val("pu_e35_state", state, 2'd3);
                check_val("pu_e35_allrel", allReleased, 1'b1);
            end
        end

        // 2. Button debounce: short glitch ignored, long press aborts, release restarts
        rstRaw = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rstRaw = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_val("btn_glitch_rst", domainRst, 3'b000);
        rstRaw = 1'b1;
        seen = 0; hit = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (!seen && domainRst == 3'b111) begin
                seen = 1;
                hit  = k;
            end
        end
        check_val("btn_press_latency", hit, 19);
        check_val("btn_press_locklost", lockLost, 1'b0);
        rstRaw = 1'b0;
        seen = 0; hit = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (!seen && !domainRst[0]) begin
                seen = 1;
                hit  = k;
            end
        end
        check_val("btn_release_to_dom0", hit, 35);
        check_val("btn_release_run", state, 2'd3);

        // 5. Mid-operation reset
        rstN = 1'b0;
        step();
        check_val("midrst_rst", domainRst, 3'b111);
        check_val("midrst_state", state, 2'd0);
        check_val("midrst_locklost", lockLost, 1'b0);
        check_val("midrst_allrel", allReleased, 1'b0);
        rstN = 1'b1;

        // 3. Lock loss during RELEASE
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            if (!domainRst[0]) seen = 1;
        end
        check_val("rel_dom0_seen", seen, 1'b1);
        locked = 2'b01;
        for (int i = 0; i < 3; i++) step();
        check_val("rel_loss_rst", domainRst, 3'b111);
        check_val("rel_loss_locklost", lockLost, 1'b1);
        locked = 2'b11;
        for (int i = 0; i < 50; i++) step();
        check_val("rel_restart_state", state, 2'd3);
        check_val("rel_sticky", lockLost, 1'b1);
        clrStatus = 1'b1;
        step();
        clrStatus = 1'b0;
        step();
        check_val("rel_cleared", lockLost, 1'b0);

        // 4. Lock loss during STRETCH
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (state == 2'd1) seen = 1;
        end
        check_val("str_entry_seen", seen, 1'b1);
        for (int i = 0; i < 10; i++) step();
        locked = 2'b10;
        for (int i = 0; i < 3; i++) step();
        check_val("str_abort_state", state, 2'd0);
        check_val("str_abort_locklost", lockLost, 1'b0);
        for (int i = 0; i < 2; i++) step();
        locked = 2'b11;
        seen = 0; entry = 0; hit = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (entry == 0 && state == 2'd1) entry = k;
            if (!seen && !domainRst[0]) begin
                seen = 1;
                hit  = k;
            end
        end
        check_val("str_restretch_len", hit - entry, SC);
        check_val("str_locklost_after", lockLost, 1'b0);

        // 6. Set/clear collision on a RUN abort
        locked = 2'b00;
        step();
        step();
        clrStatus = 1'b1;
        step();
        clrStatus = 1'b0;
        step();
        check_val("collide_locklost", lockLost, 1'b1);
        check_val("collide_rst", domainRst, 3'b111);
        locked = 2'b11;
        clrStatus = 1'b1;
        step();
        clrStatus = 1'b0;

        // Random soak
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < NL; i++) begin
                if (locked[i] ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0))
                    locked[i] = ~locked[i];
            end
            if ($urandom_range(0, 19) == 0) rstRaw = ~rstRaw;
            clrStatus = ($urandom_range(0, 29) == 0);
            rstN      = !($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
